sram_ctrl: RTL and testbench
============================

# sram_ctrl

Multi-cycle data-memory controller between the EXE/MEM pipeline register and the board's 16-bit asynchronous SRAM. It serializes one 32-bit load or store into two 16-bit half-word accesses, holds the rest of the pipeline frozen until the access completes, and returns load data to the MEM stage. The address comes from the EXE ALU result and the store data from the forwarded Rm value.

## Interface
- BASE_ADDR, 1024: byte address mapped to SRAM word 0.
- WAIT_CYCLES, 3: cycles each half-word phase is held; legal range 2..15.
- clk  in  1  clock; all state changes on rising edge.
- rest  in  1  reset, asynchronous, active-high.
- rd_en  in  1  load request (MEM_R_EN of the MEM stage).
- wr_en  in  1  store request (MEM_W_EN of the MEM stage).
- address  in  32  byte address (ALU result).
- write_data  in  32  store data.
- read_data  out  32  load result, valid while `ready`=1 after a read.
- ready  out  1  transaction complete this cycle.
- freeze  out  1  stall for all pipeline registers: (rd_en|wr_en) & ~ready.
- sram_addr  out  18  half-word address.
- sram_dq_out  out  16  write data to pad.
- sram_dq_in  in  16  read data from pad.
- sram_dq_oe  out  1  pad output enable.
- sram_we_n, sram_oe_n, sram_ce_n  out  1 each  active-low strobes. UB_N/LB_N are tied low at the top level.

## Operation
- States: IDLE, LO, HI, DONE. A phase counter runs 0..WAIT_CYCLES-1 in LO and HI, and clears on every state change.
- IDLE: if wr_en, go to LO with op=write; else if rd_en, go to LO with op=read. Write wins when both are high. On entry to LO, latch op, the word index and write_data.
- Word index: (address - BASE_ADDR) computed modulo 2^32. Bits [18:2] form a 17-bit index; bits [1:0] are ignored. Addresses below BASE_ADDR or above the range wrap silently.
- sram_addr is {index,1'b0} in LO and {index,1'b1} in HI. Outside LO/HI it is 0.
- LO→HI and HI→DONE when the counter reaches WAIT_CYCLES-1. DONE→IDLE unconditionally.
- Read: sram_oe_n=0 in LO/HI. On the final LO edge, latch sram_dq_in into read_data[15:0]. On the final HI edge, latch it into read_data[31:16]. read_data holds until the next read overwrites it.
- Write: sram_dq_oe=1 in LO/HI. sram_dq_out is the latched data [15:0] in LO and [31:16] in HI. sram_we_n=0 in LO/HI except on the counter's final cycle, which gives address/data hold before the phase changes.
- sram_ce_n=0 only in LO/HI. In IDLE/DONE all strobes are 1 and sram_dq_oe=0.
- ready=1 only in DONE.
- A request that drops mid-transaction does not abort it; it runs to DONE. An inactive request in DONE is ignored.
- Reset, asynchronous at any point including mid-transaction: state=IDLE, counter=0, read_data=0, latched data/index=0, ready=0, strobes=1, sram_dq_oe=0, sram_addr=0. A partial write is abandoned.

## Timing
- Request seen in IDLE at cycle 0:
  - LO occupies cycles 1..W.
  - HI occupies cycles W+1..2W.
  - DONE is cycle 2W+1.
  - With W=3: ready in cycle 7, and freeze is high in cycles 0..6.
- freeze is combinational from the request inputs and state. It is 0 in cycle 2W+1, so the pipeline advances on that edge.
- Back-to-back: a new request presented in the cycle after DONE is seen in IDLE that cycle. The inter-transaction gap is 0 idle cycles beyond the IDLE decision cycle.
- read_data is registered; it is valid from DONE onward.

## Structure
- Shared package `sram_pkg`:
  - state enum (IDLE, LO, HI, DONE).
  - SRAM_ADDR_W=18, SRAM_DATA_W=16.
  - default BASE_ADDR.
- One sub-module, `sram_phase_counter`: a WAIT_CYCLES-parameterized counter with clear input and `last` output.
- The FSM, latches and pad drive stay in sram_ctrl.

## Test plan
- Reset: assert rest mid-LO of a write → same cycle: sram_we_n=1, sram_dq_oe=0, ready=0, freeze=wr_en; after release, state is IDLE and read_data=0.
- Read 0x400 with pad model returning 0x1234 at half-addr 0 and 0xABCD at half-addr 1 → ready in cycle 7, read_data=0xABCD1234, freeze high exactly 7 cycles.
- Write 0xDEADBEEF to 0x404 → half-addr 2 receives 0xBEEF and half-addr 3 receives 0xDEAD. Each sram_we_n low pulse is 2 cycles long, and the address is stable throughout.
- rd_en and wr_en both high → write performed; sram_oe_n stays 1 throughout.
- Request dropped in cycle 2 of a read → transaction still reaches DONE at cycle 7 and read_data updates. Back-to-back read then write → second transaction's LO starts in cycle 9.
- Address 0x3FC (below base) → index wraps to 0x1FFFF, so sram_addr is 0x3FFFE then 0x3FFFF.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and constants for the 16-bit asynchronous SRAM data-memory controller.
package sram_pkg;

  localparam int          SRAM_ADDR_W       = 18;
  localparam int          SRAM_DATA_W       = 16;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

endpackage

// File: rtl/sram_phase_counter.sv
// Phase timer for one half-word access: counts 0..WAIT_CYCLES-1, flags the final cycle.
module sram_phase_counter #(
  parameter int WAIT_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  output logic last
);

  logic [3:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 4'd0;
    end else if (clear) begin
      count <= 4'd0;
    end else if (en) begin
      count <= count + 4'd1;
    end
  end

  assign last = (count == 4'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_ctrl.sv
// Serializes one 32-bit load/store into two timed 16-bit SRAM accesses and stalls the pipeline meanwhile.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          WAIT_CYCLES = 3
) (
  input  logic                   clk,
  input  logic                   rest,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic                   freeze,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [SRAM_DATA_W-1:0] sram_dq_out,
  input  logic [SRAM_DATA_W-1:0] sram_dq_in,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n,
  output logic                   sram_oe_n,
  output logic                   sram_ce_n
);

  state_t      state, state_next;
  op_t         op;
  logic [16:0] index;
  logic [31:0] wdata;
  logic [31:0] offset;
  logic        busy;
  logic        last;
  logic        unused_offset_bits;

  // Out-of-range addresses wrap silently: only bits [18:2] of the offset select the word.
  assign offset             = address - BASE_ADDR;
  assign unused_offset_bits = ^{offset[31:19], offset[1:0]};
  assign busy               = (state == LO) || (state == HI);

  sram_phase_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_phase (
    .clk  (clk),
    .rst  (rest),
    .en   (busy),
    .clear(state_next != state),
    .last (last)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (wr_en || rd_en) state_next = LO;
      LO:      if (last)           state_next = HI;
      HI:      if (last)           state_next = DONE;
      default:                     state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      state     <= IDLE;
      op        <= OP_READ;
      index     <= 17'd0;
      wdata     <= 32'd0;
      read_data <= 32'd0;
    end else begin
      state <= state_next;
      if (state == IDLE && (wr_en || rd_en)) begin
        op    <= wr_en ? OP_WRITE : OP_READ;
        index <= offset[18:2];
        wdata <= write_data;
      end
      if (op == OP_READ && last) begin
        if (state == LO) read_data[15:0]  <= sram_dq_in;
        if (state == HI) read_data[31:16] <= sram_dq_in;
      end
    end
  end

  always_comb begin
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    sram_oe_n   = 1'b1;
    sram_ce_n   = 1'b1;
    if (busy) begin
      sram_ce_n = 1'b0;
      sram_addr = {index, (state == HI)};
      if (op == OP_WRITE) begin
        sram_dq_oe  = 1'b1;
        sram_dq_out = (state == HI) ? wdata[31:16] : wdata[15:0];
        // Release WE one cycle early so address and data are held past the strobe edge.
        sram_we_n   = last;
      end else begin
        sram_oe_n = 1'b0;
      end
    end
  end

  assign ready  = (state == DONE);
  assign freeze = (rd_en | wr_en) & ~ready;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed-vector bench for sram_ctrl with a behavioural 16-bit SRAM model.
module tb_sram_ctrl;

  logic        clk = 1'b0;
  logic        rest;
  logic        rd_en, wr_en;
  logic [31:0] address, write_data;
  logic [31:0] read_data;
  logic        ready, freeze;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n, sram_oe_n, sram_ce_n;

  logic [15:0] mem [0:262143];

  int n_vec = 0;
  int n_bad = 0;

  int          ready_cyc, freeze_cnt, lo_start;
  logic        oe_low_seen, addr_bad, we_prev;
  int          plen;
  logic [17:0] paddr;
  int          pulses[$];
  logic [17:0] a_lo, a_hi;

  sram_ctrl #(
    .BASE_ADDR  (32'd1024),
    .WAIT_CYCLES(3)
  ) dut (
    .clk        (clk),
    .rest       (rest),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .freeze     (freeze),
    .sram_addr  (sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_in (sram_dq_in),
    .sram_dq_oe (sram_dq_oe),
    .sram_we_n  (sram_we_n),
    .sram_oe_n  (sram_oe_n),
    .sram_ce_n  (sram_ce_n)
  );

  always #5 clk = ~clk;

  assign sram_dq_in = sram_oe_n ? 16'h0000 : mem[sram_addr];

  always @(posedge clk) begin
    if (!sram_we_n && !sram_ce_n) mem[sram_addr] <= sram_dq_out;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Cycle 0 is the IDLE decision cycle; samples are taken 1 time unit after each falling edge.
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input int drop_at);
    ready_cyc   = -1;
    freeze_cnt  = 0;
    lo_start    = -1;
    oe_low_seen = 1'b0;
    addr_bad    = 1'b0;
    we_prev     = 1'b1;
    plen        = 0;
    paddr       = '0;
    a_lo        = '0;
    a_hi        = '0;
    pulses.delete();
    @(negedge clk);
    rd_en = rd; wr_en = wr; address = a; write_data = d;
    for (int c = 0; c < 40; c++) begin
      if (c == drop_at) begin
        rd_en = 1'b0; wr_en = 1'b0;
      end
      #1;
      if (freeze) freeze_cnt++;
      if (!sram_oe_n) oe_low_seen = 1'b1;
      if (!sram_ce_n && lo_start < 0) lo_start = c;
      if (c == 1) a_lo = sram_addr;
      if (c == 4) a_hi = sram_addr;
      if (!sram_we_n) begin
        if (we_prev) begin
          plen  = 1;
          paddr = sram_addr;
        end else begin
          plen++;
          if (sram_addr != paddr) addr_bad = 1'b1;
        end
      end else if (!we_prev) begin
        pulses.push_back(plen);
      end
      we_prev = sram_we_n;
      if (ready) begin
        ready_cyc = c;
        break;
      end
      @(negedge clk);
    end
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 262144; i++) mem[i] = 16'h0000;
    mem[0]       = 16'h1234;
    mem[1]       = 16'hABCD;
    mem[8]       = 16'h7777;
    mem[9]       = 16'h8888;
    mem[18'h3FFFE] = 16'h5555;
    mem[18'h3FFFF] = 16'h6666;

    rest = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_strobes", {29'd0, sram_we_n, sram_oe_n, sram_ce_n}, 32'd7);
    check("rst_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
    check("rst_addr", {14'd0, sram_addr}, 32'd0);
    check("rst_rdata", read_data, 32'd0);
    @(negedge clk);
    rest = 1'b0;

    // Basic read
    run_txn(1'b1, 1'b0, 32'h400, 32'h0, -1);
    check("rd_ready_cyc", ready_cyc, 32'd7);
    check("rd_data", read_data, 32'hABCD1234);
    check("rd_freeze_cnt", freeze_cnt, 32'd7);

    // Async reset mid-LO of a write
    @(negedge clk);
    wr_en = 1'b1; address = 32'h40C; write_data = 32'h01020304;
    repeat (2) @(negedge clk);
    #1;
    rest = 1'b1;
    #1;
    check("arst_we_n", {31'd0, sram_we_n}, 32'd1);
    check("arst_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
    check("arst_ready", {31'd0, ready}, 32'd0);
    check("arst_freeze", {31'd0, freeze}, 32'd1);
    wr_en = 1'b0;
    @(negedge clk);
    rest = 1'b0;
    #1;
    check("arst_idle_ce", {31'd0, sram_ce_n}, 32'd1);
    check("arst_rdata", read_data, 32'd0);
    check("arst_freeze_off", {31'd0, freeze}, 32'd0);

    // Write with strobe timing
    run_txn(1'b0, 1'b1, 32'h404, 32'hDEADBEEF, -1);
    @(negedge clk);
    check("wr_ready_cyc", ready_cyc, 32'd7);
    check("wr_lo_half", {16'd0, mem[2]}, 32'h0000BEEF);
    check("wr_hi_half", {16'd0, mem[3]}, 32'h0000DEAD);
    check("wr_pulse_cnt", pulses.size(), 32'd2);
    if (pulses.size() == 2) begin
      check("wr_pulse0_len", pulses[0], 32'd2);
      check("wr_pulse1_len", pulses[1], 32'd2);
    end
    check("wr_addr_stable", {31'd0, addr_bad}, 32'd0);

    // Simultaneous read and write requests: write wins
    run_txn(1'b1, 1'b1, 32'h408, 32'h11112222, -1);
    @(negedge clk);
    check("both_lo", {16'd0, mem[4]}, 32'h00002222);
    check("both_hi", {16'd0, mem[5]}, 32'h00001111);
    check("both_oe_n", {31'd0, oe_low_seen}, 32'd0);

    // Request dropped in cycle 2 still completes
    run_txn(1'b1, 1'b0, 32'h410, 32'h0, 2);
    check("drop_ready_cyc", ready_cyc, 32'd7);
    check("drop_data", read_data, 32'h88887777);

    // Back-to-back read then write
    run_txn(1'b1, 1'b0, 32'h400, 32'h0, -1);
    check("b2b_rd_ready", ready_cyc, 32'd7);
    check("b2b_rd_data", read_data, 32'hABCD1234);
    run_txn(1'b0, 1'b1, 32'h414, 32'hCAFEF00D, -1);
    check("b2b_wr_lo_start", lo_start, 32'd1);
    check("b2b_wr_ready", ready_cyc, 32'd7);
    @(negedge clk);
    check("b2b_wr_mem", {mem[11], mem[10]}, 32'hCAFEF00D);

    // Address below base wraps
    run_txn(1'b1, 1'b0, 32'h3FC, 32'h0, -1);
    check("wrap_addr_lo", {14'd0, a_lo}, 32'h0003FFFE);
    check("wrap_addr_hi", {14'd0, a_hi}, 32'h0003FFFF);
    check("wrap_data", read_data, 32'h66665555);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
